// File: rtl/het_hop_scheduler.sv
// het_hop_scheduler: frequency-hopping sequencer that drives a DDS.
// It steps through a programmable frequency table. Each hop is a one-cycle
// LOAD, then an optional SETTLE period with ch_valid low, then a DWELL
// period with ch_valid high.
// Optional build macro: HET_HOP_PHASE_RESET_EN. When it is defined,
// nco_start drops during LOAD so the DDS accumulator restarts on every hop
// (phase-coherent hops). When it is undefined, nco_start stays high while
// busy (phase-continuous hops).
module het_hop_scheduler #(
   parameter int N_CH        = 8,
   parameter int WIDTH_PHASE = 32,
   parameter int WIDTH_DWELL = 16,
   localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                   clk,
   input  logic                   reset_b,
   input  logic                   cfg_we,
   input  logic [CW-1:0]          cfg_addr,
   input  logic [WIDTH_PHASE-1:0] cfg_freq,
   input  logic [CW:0]            num_ch,
   input  logic [WIDTH_DWELL-1:0] settle,
   input  logic [WIDTH_DWELL-1:0] dwell,
   input  logic                   start,
   input  logic                   stop,
   output logic [WIDTH_PHASE-1:0] frequency,
   output logic [WIDTH_PHASE-1:0] phase,
   output logic                   nco_start,
   output logic [CW-1:0]          ch_idx,
   output logic                   hop_stb,
   output logic                   ch_valid,
   output logic                   busy
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_DWELL} state_t;

   localparam logic [CW:0] NUM_MAX = (CW+1)'(N_CH);
`ifdef HET_HOP_PHASE_RESET_EN
   localparam logic NCO_IN_LOAD = 1'b0;
`else
   localparam logic NCO_IN_LOAD = 1'b1;
`endif

   state_t                 r_state;
   logic [WIDTH_PHASE-1:0] r_table [N_CH];
   logic [CW:0]            r_num;
   logic [WIDTH_DWELL-1:0] r_settle;
   logic [WIDTH_DWELL-1:0] r_dwell;
   logic [WIDTH_DWELL-1:0] r_cnt;
   logic [WIDTH_PHASE-1:0] r_frequency;
   logic [CW-1:0]          r_ch_idx;
   logic                   r_hop_stb;
   logic                   r_ch_valid;
   logic                   r_busy;
   logic                   r_nco_start;

   logic [CW:0]            w_num_eff;
   logic [CW:0]            w_last;
   logic [CW-1:0]          w_ch_next;
   logic [WIDTH_DWELL-1:0] w_dwell_load;

   // Clamp the live channel count into 1..N_CH. Compute the wrap point from
   // the latched count and the down-counter preload for DWELL.
   always_comb begin
      w_num_eff = num_ch;
      if (num_ch == '0)
         w_num_eff = (CW+1)'(1);
      else if (num_ch > NUM_MAX)
         w_num_eff = NUM_MAX;
      w_last       = r_num - (CW+1)'(1);
      w_ch_next    = ({1'b0, r_ch_idx} >= w_last) ? '0 : r_ch_idx + CW'(1);
      w_dwell_load = (r_dwell == '0) ? '0 : r_dwell - WIDTH_DWELL'(1);
   end

   // Frequency table. Each entry takes writes at any time. A write that
   // lands on the same edge as a LOAD of that entry is seen on the next hop.
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_table
         // One table entry: cleared by reset, otherwise written on address match.
         always_ff @(posedge clk) begin
            if (!reset_b)
               r_table[gi] <= '0;
            else if (cfg_we && (cfg_addr == CW'(gi)))
               r_table[gi] <= cfg_freq;
         end
      end
   endgenerate

   // Hop FSM. Registered outputs are updated on the edge that enters each
   // state. Configuration is latched on the edge that enters LOAD.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         r_state     <= S_IDLE;
         r_num       <= '0;
         r_settle    <= '0;
         r_dwell     <= '0;
         r_cnt       <= '0;
         r_frequency <= '0;
         r_ch_idx    <= '0;
         r_hop_stb   <= 1'b0;
         r_ch_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_nco_start <= 1'b0;
      end else if (stop) begin
         r_state     <= S_IDLE;
         r_hop_stb   <= 1'b0;
         r_ch_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_nco_start <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_LOAD;
                  r_ch_idx    <= '0;
                  r_frequency <= r_table[0];
                  r_num       <= w_num_eff;
                  r_settle    <= settle;
                  r_dwell     <= dwell;
                  r_hop_stb   <= 1'b1;
                  r_busy      <= 1'b1;
                  r_nco_start <= NCO_IN_LOAD;
               end
            end
            S_LOAD: begin
               r_hop_stb   <= 1'b0;
               r_nco_start <= 1'b1;
               if (r_settle != '0) begin
                  r_state <= S_SETTLE;
                  r_cnt   <= r_settle - WIDTH_DWELL'(1);
               end else begin
                  r_state    <= S_DWELL;
                  r_cnt      <= w_dwell_load;
                  r_ch_valid <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (r_cnt == '0) begin
                  r_state    <= S_DWELL;
                  r_cnt      <= w_dwell_load;
                  r_ch_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - WIDTH_DWELL'(1);
               end
            end
            S_DWELL: begin
               if (r_cnt == '0) begin
                  r_state     <= S_LOAD;
                  r_ch_idx    <= w_ch_next;
                  r_frequency <= r_table[w_ch_next];
                  r_num       <= w_num_eff;
                  r_settle    <= settle;
                  r_dwell     <= dwell;
                  r_hop_stb   <= 1'b1;
                  r_ch_valid  <= 1'b0;
                  r_nco_start <= NCO_IN_LOAD;
               end else begin
                  r_cnt <= r_cnt - WIDTH_DWELL'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign frequency = r_frequency;
   assign phase     = '0;
   assign nco_start = r_nco_start;
   assign ch_idx    = r_ch_idx;
   assign hop_stb   = r_hop_stb;
   assign ch_valid  = r_ch_valid;
   assign busy      = r_busy;

endmodule

// File: tb/tb_het_hop_scheduler.sv
// Directed testbench for het_hop_scheduler: a cycle table for the basic hop
// sequence and stop/restart, plus hand-written corner sequences.
module tb_het_hop_scheduler;

   localparam logic [31:0] F0   = 32'd3285649981;
   localparam logic [31:0] F1   = 32'd1052266988;
   localparam logic [31:0] F2   = 32'h40000000;
   localparam logic [31:0] NEW1 = 32'h12345678;
   localparam logic [31:0] NEW2 = 32'h0badcafe;

   logic        clk = 1'b0;
   logic        reset_b, cfg_we, start, stop;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_freq;
   logic [3:0]  num_ch;
   logic [15:0] settle, dwell;
   logic [31:0] frequency, phase;
   logic        nco_start, hop_stb, ch_valid, busy;
   logic [2:0]  ch_idx;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        start;
      logic        stop;
      logic        hop;
      logic        valid;
      logic        busy;
      logic [2:0]  ch;
      logic [31:0] freq;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   het_hop_scheduler dut (
      .clk(clk), .reset_b(reset_b), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_freq(cfg_freq), .num_ch(num_ch), .settle(settle), .dwell(dwell),
      .start(start), .stop(stop), .frequency(frequency), .phase(phase),
      .nco_start(nco_start), .ch_idx(ch_idx), .hop_stb(hop_stb),
      .ch_valid(ch_valid), .busy(busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic logic exp_nco(input logic b, input logic h);
`ifdef HET_HOP_PHASE_RESET_EN
      return b & ~h;
`else
      return b;
`endif
   endfunction

   task automatic add(input int n, input logic st, input logic sp, input logic h,
                      input logic v, input logic b, input logic [2:0] c, input logic [31:0] f);
      vec_t e;
      e.start = st; e.stop = sp; e.hop = h; e.valid = v; e.busy = b; e.ch = c; e.freq = f;
      for (int i = 0; i < n; i++) vecs.push_back(e);
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_freq = d;
      step();
      cfg_we = 1'b0;
      $display("cfg write table[%0d] = 0x%08h", a, d);
   endtask

   task automatic wait_hop(input logic [2:0] c, input string nm);
      bit found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         step();
         if (hop_stb && ch_idx == c) found = 1'b1;
      end
      chk({nm, "_timeout"}, 32'(found), 32'd1);
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_freq"}, frequency, 32'd0);
      chk({nm, "_ch"}, 32'(ch_idx), 32'd0);
      chk({nm, "_hop"}, 32'(hop_stb), 32'd0);
      chk({nm, "_valid"}, 32'(ch_valid), 32'd0);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_nco"}, 32'(nco_start), 32'd0);
      chk({nm, "_phase"}, phase, 32'd0);
   endtask

   initial begin
      reset_b = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_freq = '0;
      num_ch = 4'd3; settle = 16'd2; dwell = 16'd4; start = 1'b0; stop = 1'b0;
      step(); step();
      check_all_zero("reset");
      $display("reset applied");
      reset_b = 1'b1;
      step();

      cfg_write(3'd0, F0);
      cfg_write(3'd1, F1);
      cfg_write(3'd2, F2);

      // Hop sequence with num_ch=3, settle=2, dwell=4 (period 7), then stop
      // one cycle into the DWELL of channel 1, idle, and restart.
      add(1, 1, 0, 1, 0, 1, 0, F0);
      add(2, 0, 0, 0, 0, 1, 0, F0);
      add(4, 0, 0, 0, 1, 1, 0, F0);
      add(1, 0, 0, 1, 0, 1, 1, F1);
      add(2, 0, 0, 0, 0, 1, 1, F1);
      add(4, 0, 0, 0, 1, 1, 1, F1);
      add(1, 0, 0, 1, 0, 1, 2, F2);
      add(2, 0, 0, 0, 0, 1, 2, F2);
      add(4, 0, 0, 0, 1, 1, 2, F2);
      add(1, 0, 0, 1, 0, 1, 0, F0);
      add(2, 0, 0, 0, 0, 1, 0, F0);
      add(4, 0, 0, 0, 1, 1, 0, F0);
      add(1, 0, 0, 1, 0, 1, 1, F1);
      add(2, 0, 0, 0, 0, 1, 1, F1);
      add(1, 0, 0, 0, 1, 1, 1, F1);
      add(1, 0, 1, 0, 0, 0, 1, F1);
      add(1, 0, 0, 0, 0, 0, 1, F1);
      add(1, 1, 0, 1, 0, 1, 0, F0);
      add(1, 0, 1, 0, 0, 0, 0, F0);

      for (int i = 0; i < vecs.size(); i++) begin
         start = vecs[i].start;
         stop  = vecs[i].stop;
         step();
         $display("vec %0d: start=%0b stop=%0b -> hop=%0b valid=%0b busy=%0b ch=%0d freq=0x%08h nco=%0b",
                  i, start, stop, hop_stb, ch_valid, busy, ch_idx, frequency, nco_start);
         chk($sformatf("v%0d_hop", i), 32'(hop_stb), 32'(vecs[i].hop));
         chk($sformatf("v%0d_valid", i), 32'(ch_valid), 32'(vecs[i].valid));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         chk($sformatf("v%0d_ch", i), 32'(ch_idx), 32'(vecs[i].ch));
         chk($sformatf("v%0d_freq", i), frequency, vecs[i].freq);
         chk($sformatf("v%0d_nco", i), 32'(nco_start), 32'(exp_nco(vecs[i].busy, vecs[i].hop)));
         chk($sformatf("v%0d_phase", i), phase, 32'd0);
      end
      stop = 1'b0;

      // settle=0, dwell=0, num_ch=1: LOAD and DWELL alternate on channel 0.
      num_ch = 4'd1; settle = 16'd0; dwell = 16'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("min_first_hop", 32'(hop_stb), 32'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         $display("min hop cycle %0d: hop=%0b valid=%0b ch=%0d", i, hop_stb, ch_valid, ch_idx);
         chk($sformatf("min_hop_%0d", i), 32'(hop_stb), 32'(i % 2));
         chk($sformatf("min_valid_%0d", i), 32'(ch_valid), 32'((i + 1) % 2));
         chk($sformatf("min_ch_%0d", i), 32'(ch_idx), 32'd0);
      end
      stop = 1'b1; step(); stop = 1'b0;

      // Table writes: a write during DWELL of channel 1 is seen at the next
      // LOAD of index 2; a write on the LOAD edge of index 2 is seen one hop later.
      num_ch = 4'd3; settle = 16'd0; dwell = 16'd2;
      start = 1'b1; step(); start = 1'b0;
      wait_hop(3'd1, "wr_hop1a");
      step();
      cfg_we = 1'b1; cfg_addr = 3'd2; cfg_freq = NEW1;
      step();
      cfg_we = 1'b0;
      chk("wr_dwell_valid", 32'(ch_valid), 32'd1);
      step();
      $display("after dwell write: hop=%0b ch=%0d freq=0x%08h", hop_stb, ch_idx, frequency);
      chk("wr_dwell_hop", 32'(hop_stb), 32'd1);
      chk("wr_dwell_ch", 32'(ch_idx), 32'd2);
      chk("wr_dwell_freq", frequency, NEW1);
      wait_hop(3'd1, "wr_hop1b");
      step(); step();
      cfg_we = 1'b1; cfg_addr = 3'd2; cfg_freq = NEW2;
      step();
      cfg_we = 1'b0;
      $display("coincident write: hop=%0b ch=%0d freq=0x%08h", hop_stb, ch_idx, frequency);
      chk("wr_coinc_hop", 32'(hop_stb), 32'd1);
      chk("wr_coinc_ch", 32'(ch_idx), 32'd2);
      chk("wr_coinc_freq", frequency, NEW1);
      wait_hop(3'd2, "wr_hop2");
      chk("wr_later_freq", frequency, NEW2);
      stop = 1'b1; step(); stop = 1'b0;

      // Reset during SETTLE, then start held with stop, then table cleared.
      settle = 16'd3; dwell = 16'd2;
      start = 1'b1; step(); start = 1'b0;
      chk("rs_load_freq", frequency, F0);
      step();
      chk("rs_in_settle_valid", 32'(ch_valid), 32'd0);
      chk("rs_in_settle_busy", 32'(busy), 32'd1);
      reset_b = 1'b0;
      step();
      $display("reset mid-settle: busy=%0b freq=0x%08h", busy, frequency);
      check_all_zero("rs_mid");
      reset_b = 1'b1; start = 1'b1; stop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rs_startstop_busy_%0d", i), 32'(busy), 32'd0);
         chk($sformatf("rs_startstop_hop_%0d", i), 32'(hop_stb), 32'd0);
      end
      stop = 1'b0;
      step();
      start = 1'b0;
      $display("post-reset start: hop=%0b freq=0x%08h", hop_stb, frequency);
      chk("rs_restart_hop", 32'(hop_stb), 32'd1);
      chk("rs_table_cleared", frequency, 32'd0);
      stop = 1'b1; step(); stop = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
